// File: rtl/counter_updown4b_pkg.sv
// Shared direction encodings and terminal-value helper for the up/down counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Counting up ends at MOD-1; counting down ends at 0.
    function automatic int unsigned tc_value(input logic dir, input int unsigned mod);
        return (dir == DIR_UP) ? (mod - 1) : 0;
    endfunction

endpackage

// File: rtl/counter_updown4b_if.sv
// Control and status bundle between a counter stage and whatever drives it.
interface counter_updown4b_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             ci;
    logic             dir;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] Q;
    logic             Rc;
    logic             tc;

    modport master (
        output en, ci, dir, ld, d,
        input  Q, Rc, tc
    );

    modport slave (
        input  en, ci, dir, ld, d,
        output Q, Rc, tc
    );
endinterface

// File: rtl/counter_updown4b_nextstate.sv
// Combinational next-count: load with saturation, then up/down modulo step, else hold.
module counter_nextstate
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ld_i,
    input  logic             en_i,
    input  logic             ci_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] q_o
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(tc_value(DIR_UP, unsigned'(MOD)));
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        q_o = q_i;
        if (ld_i) begin
            // Loads above the modulus clamp to the top value so Q stays in range.
            q_o = (d_i > MAX) ? MAX : d_i;
        end else if (en_i && ci_i) begin
            if (dir_i == DIR_UP) begin
                q_o = (q_i == MAX) ? '0 : q_i + ONE;
            end else begin
                q_o = (q_i == '0) ? MAX : q_i - ONE;
            end
        end
    end

endmodule

// File: rtl/counter_updown4b.sv
// Loadable, cascadable up/down modulo counter stage: count register plus combinational tc/Rc.
module counter_updown4b
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    counter_updown4b_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 8 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
        $error("counter_updown4b: WIDTH or MOD out of legal range");
    end

    localparam logic [WIDTH-1:0] TC_UP   = WIDTH'(tc_value(DIR_UP, unsigned'(MOD)));
    localparam logic [WIDTH-1:0] TC_DOWN = WIDTH'(tc_value(DIR_DOWN, unsigned'(MOD)));

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_w;

    counter_nextstate #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_nextstate (
        .q_i   (q_q),
        .d_i   (bus.d),
        .ld_i  (bus.ld),
        .en_i  (bus.en),
        .ci_i  (bus.ci),
        .dir_i (bus.dir),
        .q_o   (q_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // tc and Rc are combinational so a chained stage sees the carry in the same cycle.
    assign tc_w   = (q_q == ((bus.dir == DIR_UP) ? TC_UP : TC_DOWN));
    assign bus.tc = tc_w;
    assign bus.Rc = tc_w & bus.en & bus.ci;
    assign bus.Q  = q_q;

endmodule

// File: tb/tb_counter_updown4b.sv
// Self-checking bench for counter_updown4b: reset, wrap, modulus, priority, direction, cascade.
module tb_counter_updown4b;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a, rst_m, rst_c;

    counter_updown4b_if #(.WIDTH(4)) bus_a ();
    counter_updown4b_if #(.WIDTH(4)) bus_m ();
    counter_updown4b_if #(.WIDTH(4)) bus_c0 ();
    counter_updown4b_if #(.WIDTH(4)) bus_c1 ();

    counter_updown4b #(.WIDTH(4), .MOD(16)) dut_a  (.clk(clk), .rst(rst_a), .bus(bus_a));
    counter_updown4b #(.WIDTH(4), .MOD(10)) dut_m  (.clk(clk), .rst(rst_m), .bus(bus_m));
    counter_updown4b #(.WIDTH(4), .MOD(16)) dut_c0 (.clk(clk), .rst(rst_c), .bus(bus_c0));
    counter_updown4b #(.WIDTH(4), .MOD(16)) dut_c1 (.clk(clk), .rst(rst_c), .bus(bus_c1));

    assign bus_c1.ci = bus_c0.Rc;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    function automatic int model_next(int q, int d, bit ld, bit en, bit ci, bit dir, int mod);
        if (ld) return (d >= mod) ? mod - 1 : d;
        if (en && ci) return dir ? (q + mod - 1) % mod : (q + 1) % mod;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        bus_a.ld = 1'b1; bus_a.d = 4'd9; bus_a.en = 1'b0; bus_a.ci = 1'b1; bus_a.dir = 1'b0;
        tick();
        bus_a.ld = 1'b0;
        checks++;
        if (bus_a.Q !== 4'd9) begin errors++; $display("FAIL rst_preload: Q=%0d expected 9", bus_a.Q); end
        #5;
        bus_a.dir = 1'b1; bus_a.en = 1'b1; bus_a.ci = 1'b1;
        rst_a = 1'b1;
        #1;
        checks++;
        if (bus_a.Q !== 4'd0) begin errors++; $display("FAIL rst_async_q: Q=%0d expected 0", bus_a.Q); end
        checks++;
        if (bus_a.tc !== 1'b1) begin errors++; $display("FAIL rst_down_tc: tc=%b expected 1", bus_a.tc); end
        checks++;
        if (bus_a.Rc !== 1'b1) begin errors++; $display("FAIL rst_down_rc: Rc=%b expected 1", bus_a.Rc); end
        bus_a.dir = 1'b0;
        #1;
        checks++;
        if (bus_a.tc !== 1'b0 || bus_a.Rc !== 1'b0) begin
            errors++; $display("FAIL rst_up_flags: tc=%b Rc=%b expected 0 0", bus_a.tc, bus_a.Rc);
        end
        bus_a.ld = 1'b1; bus_a.d = 4'd5;
        tick();
        bus_a.ld = 1'b0;
        checks++;
        if (bus_a.Q !== 4'd0) begin errors++; $display("FAIL rst_over_load: Q=%0d expected 0", bus_a.Q); end
    endtask

    task automatic test_up_wrap();
        int q = 0;
        int e;
        bus_a.dir = 1'b0; bus_a.en = 1'b1; bus_a.ci = 1'b1; bus_a.ld = 1'b0; bus_a.d = 4'd0;
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus_a.Rc !== (q == 15)) begin
                errors++; $display("FAIL up_rc[%0d]: Rc=%b expected %b", i, bus_a.Rc, (q == 15));
            end
            q = model_next(q, 0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
            exp_q.push_back(q);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus_a.Q !== 4'(e)) begin errors++; $display("FAIL up_q[%0d]: Q=%0d expected %0d", i, bus_a.Q, e); end
        end
        checks++;
        if (bus_a.Q !== 4'd4) begin errors++; $display("FAIL up_final: Q=%0d expected 4", bus_a.Q); end
    endtask

    task automatic test_down_mod();
        int q;
        int e;
        int dvals[5] = '{12, 10, 15, 9, 0};
        bus_m.dir = 1'b1; bus_m.en = 1'b0; bus_m.ci = 1'b1; bus_m.ld = 1'b1; bus_m.d = 4'd3;
        tick();
        bus_m.ld = 1'b0; bus_m.en = 1'b1;
        checks++;
        if (bus_m.Q !== 4'd3) begin errors++; $display("FAIL down_load: Q=%0d expected 3", bus_m.Q); end
        q = 3;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus_m.Rc !== (q == 0)) begin
                errors++; $display("FAIL down_rc[%0d]: Rc=%b expected %b", i, bus_m.Rc, (q == 0));
            end
            q = model_next(q, 0, 1'b0, 1'b1, 1'b1, 1'b1, 10);
            exp_q.push_back(q);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus_m.Q !== 4'(e)) begin errors++; $display("FAIL down_q[%0d]: Q=%0d expected %0d", i, bus_m.Q, e); end
        end
        checks++;
        if (bus_m.Q !== 4'd8) begin errors++; $display("FAIL down_final: Q=%0d expected 8", bus_m.Q); end
        bus_m.en = 1'b0;
        foreach (dvals[i]) begin
            bus_m.ld = 1'b1; bus_m.d = 4'(dvals[i]);
            exp_q.push_back(model_next(q, dvals[i], 1'b1, 1'b0, 1'b1, 1'b1, 10));
            tick();
            e = exp_q.pop_front();
            q = e;
            checks++;
            if (bus_m.Q !== 4'(e)) begin errors++; $display("FAIL sat_load d=%0d: Q=%0d expected %0d", dvals[i], bus_m.Q, e); end
        end
        bus_m.ld = 1'b0;
    endtask

    task automatic test_priority_hold();
        bus_a.ld = 1'b1; bus_a.d = 4'd7; bus_a.en = 1'b0;
        tick();
        bus_a.en = 1'b1; bus_a.ci = 1'b1; bus_a.dir = 1'b0; bus_a.d = 4'd5;
        tick();
        bus_a.ld = 1'b0;
        checks++;
        if (bus_a.Q !== 4'd5) begin errors++; $display("FAIL ld_over_count: Q=%0d expected 5", bus_a.Q); end
        bus_a.ci = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus_a.Q !== 4'd5 || bus_a.Rc !== 1'b0) begin
                errors++; $display("FAIL hold_ci0[%0d]: Q=%0d Rc=%b expected 5 0", i, bus_a.Q, bus_a.Rc);
            end
        end
        bus_a.ld = 1'b1; bus_a.d = 4'd15;
        tick();
        bus_a.ld = 1'b0;
        checks++;
        if (bus_a.tc !== 1'b1 || bus_a.Rc !== 1'b0) begin
            errors++; $display("FAIL tc_vs_rc: tc=%b Rc=%b expected 1 0", bus_a.tc, bus_a.Rc);
        end
        bus_a.ci = 1'b1; bus_a.ld = 1'b1; bus_a.d = 4'd6;
        rst_a = 1'b1;
        tick();
        checks++;
        if (bus_a.Q !== 4'd0) begin errors++; $display("FAIL rst_same_edge: Q=%0d expected 0", bus_a.Q); end
        rst_a = 1'b0; bus_a.ld = 1'b0;
    endtask

    task automatic test_dir_change();
        bus_a.ld = 1'b1; bus_a.d = 4'd14; bus_a.dir = 1'b0; bus_a.en = 1'b1; bus_a.ci = 1'b1;
        tick();
        bus_a.ld = 1'b0;
        tick();
        checks++;
        if (bus_a.Q !== 4'd15 || bus_a.Rc !== 1'b1) begin
            errors++; $display("FAIL dir_up_step: Q=%0d Rc=%b expected 15 1", bus_a.Q, bus_a.Rc);
        end
        bus_a.dir = 1'b1;
        #1;
        checks++;
        if (bus_a.Rc !== 1'b0 || bus_a.tc !== 1'b0) begin
            errors++; $display("FAIL dir_flip_rc: Rc=%b tc=%b expected 0 0", bus_a.Rc, bus_a.tc);
        end
        tick();
        checks++;
        if (bus_a.Q !== 4'd14) begin errors++; $display("FAIL dir_down_step: Q=%0d expected 14", bus_a.Q); end
    endtask

    task automatic test_cascade();
        int v;
        int e;
        logic [7:0] got;
        rst_c = 1'b0;
        bus_c0.ld = 1'b1; bus_c0.d = 4'd15; bus_c1.ld = 1'b1; bus_c1.d = 4'd0;
        bus_c0.en = 1'b1; bus_c1.en = 1'b1; bus_c0.ci = 1'b1; bus_c0.dir = 1'b0; bus_c1.dir = 1'b0;
        tick();
        bus_c0.ld = 1'b0; bus_c1.ld = 1'b0;
        checks++;
        if ({bus_c1.Q, bus_c0.Q} !== 8'h0F) begin errors++; $display("FAIL casc_load: Q=%h expected 0f", {bus_c1.Q, bus_c0.Q}); end
        tick();
        checks++;
        if ({bus_c1.Q, bus_c0.Q} !== 8'h10) begin errors++; $display("FAIL casc_up: Q=%h expected 10", {bus_c1.Q, bus_c0.Q}); end
        bus_c0.dir = 1'b1; bus_c1.dir = 1'b1;
        tick();
        checks++;
        if ({bus_c1.Q, bus_c0.Q} !== 8'h0F) begin errors++; $display("FAIL casc_down: Q=%h expected 0f", {bus_c1.Q, bus_c0.Q}); end
        bus_c0.dir = 1'b0; bus_c1.dir = 1'b0;
        v = 15;
        for (int i = 0; i < 256; i++) begin
            v = (v + 1) % 256;
            exp_q.push_back(v);
            tick();
            e = exp_q.pop_front();
            got = {bus_c1.Q, bus_c0.Q};
            checks++;
            if (got !== 8'(e)) begin errors++; $display("FAIL casc_run[%0d]: Q=%h expected %h", i, got, 8'(e)); end
        end
        checks++;
        if ({bus_c1.Q, bus_c0.Q} !== 8'h0F) begin errors++; $display("FAIL casc_256: Q=%h expected 0f", {bus_c1.Q, bus_c0.Q}); end
    endtask

    initial begin
        rst_a = 1'b1; rst_m = 1'b1; rst_c = 1'b1;
        bus_a.en = 1'b0; bus_a.ci = 1'b1; bus_a.dir = 1'b0; bus_a.ld = 1'b0; bus_a.d = '0;
        bus_m.en = 1'b0; bus_m.ci = 1'b1; bus_m.dir = 1'b0; bus_m.ld = 1'b0; bus_m.d = '0;
        bus_c0.en = 1'b0; bus_c0.ci = 1'b1; bus_c0.dir = 1'b0; bus_c0.ld = 1'b0; bus_c0.d = '0;
        bus_c1.en = 1'b0; bus_c1.dir = 1'b0; bus_c1.ld = 1'b0; bus_c1.d = '0;
        tick();
        checks++;
        if (bus_a.Q !== 4'd0 || bus_a.tc !== 1'b0 || bus_a.Rc !== 1'b0) begin
            errors++; $display("FAIL reset_state: Q=%0d tc=%b Rc=%b expected 0 0 0", bus_a.Q, bus_a.tc, bus_a.Rc);
        end
        rst_m = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_mod();
        test_priority_hold();
        test_dir_change();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
